// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode map, control FSM states and the default width.
package alu_seq_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [3:0] {
        OpAdd  = 4'h0,
        OpSub  = 4'h1,
        OpAnd  = 4'h2,
        OpOr   = 4'h3,
        OpXor  = 4'h4,
        OpNot  = 4'h5,
        OpShl  = 4'h6,
        OpShr  = 4'h7,
        OpAsr  = 4'h8,
        OpAdc  = 4'h9,
        OpSbb  = 4'hA,
        OpCmp  = 4'hB,
        OpMul  = 4'hC,
        OpRol  = 4'hD,
        OpPass = 4'hE,
        OpIll  = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_e;

    // Ops whose carry result is written back to the carry register.
    function automatic logic is_arith(input op_e op);
        return op inside {OpAdd, OpSub, OpAdc, OpSbb, OpCmp};
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle, done pulses after WIDTH cycles.
module alu_mul_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   prod_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign done_o = done_q;
    assign prod_o = acc_q;

endmodule

// File: rtl/alu_seq_param.sv
// Sequential ALU with valid/ready handshakes on both sides; single-cycle ops plus a multi-cycle MUL.
module alu_seq_param
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned MUL_EN = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [4+2*WIDTH-1:0]   INSTR,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [WIDTH-1:0]       Y,
    output logic                   C,
    output logic                   V,
    output logic                   N,
    output logic                   Z,
    output logic                   ILLEGAL
);

    localparam int unsigned ShW = $clog2(WIDTH);
    localparam int unsigned Msb = WIDTH - 1;

    state_e           state_q, state_d;
    logic             cf_q, cf_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d, ill_q, ill_d;

    op_e              op;
    logic [WIDTH-1:0] a, b;
    logic [ShW-1:0]   sh;
    logic             accept, mul_op;

    logic [WIDTH-1:0] res_y;
    logic             res_c, res_v, res_ill;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] rot;

    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign op     = op_e'(INSTR[4+2*WIDTH-1 -: 4]);
    assign a      = INSTR[2*WIDTH-1:WIDTH];
    assign b      = INSTR[WIDTH-1:0];
    assign sh     = b[ShW-1:0];
    assign mul_op = (op == OpMul) && (MUL_EN != 0);

    assign IN_READY  = !RST && ((state_q == StIdle) || (state_q == StDone && OUT_READY));
    assign accept    = IN_VALID && IN_READY;
    assign OUT_VALID = (state_q == StDone);

    // cf_q already holds the previous result's carry while it is presented, so an ADC/SBB
    // accepted on that hand-off sees it without a separate bypass path.
    always_comb begin
        res_y   = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_ill = 1'b0;
        wide    = '0;
        rot     = '0;
        unique case (op)
            OpAdd, OpAdc: begin
                wide  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OpAdc) & cf_q};
                res_y = wide[WIDTH-1:0];
                res_c = wide[WIDTH];
                res_v = (a[Msb] == b[Msb]) && (wide[Msb] != a[Msb]);
            end
            OpSub, OpSbb, OpCmp: begin
                wide  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OpSbb) & cf_q};
                res_y = (op == OpCmp) ? a : wide[WIDTH-1:0];
                res_c = wide[WIDTH];
                res_v = (a[Msb] != b[Msb]) && (wide[Msb] != a[Msb]);
            end
            OpAnd:  res_y = a & b;
            OpOr:   res_y = a | b;
            OpXor:  res_y = a ^ b;
            OpNot:  res_y = ~a;
            OpShl: begin
                wide  = {1'b0, a} << sh;
                res_y = wide[WIDTH-1:0];
                res_c = wide[WIDTH];
            end
            OpShr: begin
                wide  = {a, 1'b0} >> sh;
                res_y = wide[WIDTH:1];
                res_c = wide[0];
            end
            OpAsr: begin
                wide  = $signed({a, 1'b0}) >>> sh;
                res_y = wide[WIDTH:1];
                res_c = wide[0];
            end
            OpRol: begin
                rot   = (a << sh) | (a >> (WIDTH - 32'(sh)));
                res_y = rot;
                res_c = (sh != '0) && rot[0];
            end
            OpPass: res_y = b;
            OpMul:  res_ill = (MUL_EN == 0);
            OpIll:  res_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = mul_op ? StMul : StDone;
                end
            end
            StMul: begin
                if (mul_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (OUT_READY) begin
                    state_d = !accept ? StIdle : (mul_op ? StMul : StDone);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cf_d  = cf_q;
        y_d   = y_q;
        c_d   = c_q;
        v_d   = v_q;
        n_d   = n_q;
        z_d   = z_q;
        ill_d = ill_q;
        if (accept && !mul_op) begin
            y_d   = res_y;
            c_d   = res_c;
            v_d   = res_v;
            n_d   = res_y[Msb];
            z_d   = (res_y == '0);
            ill_d = res_ill;
            if (is_arith(op)) begin
                cf_d = res_c;
            end
        end else if (state_q == StMul && mul_done) begin
            y_d   = mul_prod[WIDTH-1:0];
            c_d   = |mul_prod[2*WIDTH-1:WIDTH];
            v_d   = |mul_prod[2*WIDTH-1:WIDTH];
            n_d   = mul_prod[Msb];
            z_d   = (mul_prod[WIDTH-1:0] == '0);
            ill_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cf_q    <= 1'b0;
            y_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cf_q    <= cf_d;
            y_q     <= y_d;
            c_q     <= c_d;
            v_q     <= v_d;
            n_q     <= n_d;
            z_q     <= z_d;
            ill_q   <= ill_d;
        end
    end

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (accept && mul_op),
        .a_i     (a),
        .b_i     (b),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    assign Y       = y_q;
    assign C       = c_q;
    assign V       = v_q;
    assign N       = n_q;
    assign Z       = z_q;
    assign ILLEGAL = ill_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param at WIDTH=8: directed scenarios plus a random back-pressured stream.
module tb_alu_seq_param;

    localparam int unsigned W = 8;

    logic           CLK = 1'b0;
    logic           RST;
    logic           IN_VALID;
    logic           IN_READY;
    logic [4+2*W-1:0] INSTR;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic [W-1:0]   Y;
    logic           C, V, N, Z, ILLEGAL;

    always #5 CLK = ~CLK;

    alu_seq_param #(
        .WIDTH  (W),
        .MUL_EN (1)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .INSTR     (INSTR),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Y         (Y),
        .C         (C),
        .V         (V),
        .N         (N),
        .Z         (Z),
        .ILLEGAL   (ILLEGAL)
    );

    typedef struct packed {
        logic [7:0] y;
        logic       c, v, n, z, ill;
        logic [7:0] id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_sent   = 0;
    int   cyc      = 0;
    logic model_cf = 1'b0;
    bit   stream_done;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model in plain integer arithmetic; tracks the carry register itself.
    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output exp_t e);
        int ai, bi, sa, sbi, r, s, ci;
        logic [7:0] y;
        logic c, v, ill, ar;
        ai = int'(a); bi = int'(b);
        sa = a[7] ? ai - 256 : ai;
        sbi = b[7] ? bi - 256 : bi;
        s = int'(b[2:0]);
        ci = int'(model_cf);
        y = 8'h00; c = 1'b0; v = 1'b0; ill = 1'b0; ar = 1'b0;
        case (op)
            4'h0, 4'h9: begin
                if (op == 4'h0) ci = 0;
                r = ai + bi + ci; y = r[7:0]; c = (r > 255);
                v = (sa + sbi + ci > 127) || (sa + sbi + ci < -128); ar = 1'b1;
            end
            4'h1, 4'hA, 4'hB: begin
                if (op != 4'hA) ci = 0;
                r = ai - bi - ci; y = (op == 4'hB) ? a : r[7:0]; c = (ai < bi + ci);
                v = (sa - sbi - ci > 127) || (sa - sbi - ci < -128); ar = 1'b1;
            end
            4'h2: y = a & b;
            4'h3: y = a | b;
            4'h4: y = a ^ b;
            4'h5: y = ~a;
            4'h6: begin
                r = ai << s; y = r[7:0]; c = (s != 0) && (((ai >> (8 - s)) & 1) != 0);
            end
            4'h7: begin
                r = ai >> s; y = r[7:0]; c = (s != 0) && (((ai >> (s - 1)) & 1) != 0);
            end
            4'h8: begin
                r = sa >>> s; y = r[7:0]; c = (s != 0) && (((sa >>> (s - 1)) & 1) != 0);
            end
            4'hC: begin
                r = ai * bi; y = r[7:0]; c = (r > 255); v = c;
            end
            4'hD: begin
                r = (ai << s) | (ai >> (8 - s)); y = r[7:0]; c = (s != 0) && y[0];
            end
            4'hE: y = b;
            default: ill = 1'b1;
        endcase
        if (ar) model_cf = c;
        e.y = y; e.c = c; e.v = v; e.n = y[7]; e.z = (y == 8'h00); e.ill = ill;
        e.id = 8'(n_sent);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Call with time just after a rising edge; returns 1 time unit after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit expect_out, output int acc_cyc);
        exp_t e;
        bit ok;
        ok = 1'b0;
        IN_VALID = 1'b1;
        INSTR = {op, a, b};
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge CLK);
            ok = IN_READY;
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
        acc_cyc = cyc;
        if (!ok) begin
            check("accept_timeout", 0, 1);
        end else if (expect_out) begin
            model(op, a, b, e);
            sb.push_back(e);
        end
        n_sent++;
    endtask

    always @(negedge CLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("y#%0d", e.id), Y, e.y);
                check($sformatf("cvnz#%0d", e.id), {C, V, N, Z}, {e.c, e.v, e.n, e.z});
                check($sformatf("illegal#%0d", e.id), ILLEGAL, e.ill);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1, saw;
        RST = 1'b1;
        IN_VALID = 1'b1;
        INSTR = {4'h0, 8'h12, 8'h34};
        OUT_READY = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_in_ready", IN_READY, 0);
        check("rst_y", Y, 0);
        check("rst_flags", {C, V, N, Z, ILLEGAL}, 0);
        IN_VALID = 1'b0;
        RST = 1'b0;
        step();

        send(4'h0, 8'h28, 8'h14, 1, t0);
        @(negedge CLK);
        check("add_latency", OUT_VALID, 1);
        step();

        // Back-to-back ADD then ADC: the ADC must see the ADD carry.
        send(4'h0, 8'hF0, 8'h14, 1, t0);
        send(4'h9, 8'h01, 8'h01, 1, t1);
        check("b2b_gap", t1 - t0, 1);
        send(4'h1, 8'h1E, 8'h1E, 1, t0);
        send(4'h1, 8'h3C, 8'h50, 1, t0);
        send(4'hF, 8'hAA, 8'h55, 1, t0);
        send(4'h9, 8'h00, 8'h00, 1, t0);

        send(4'hC, 8'h11, 8'h33, 1, t0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            check($sformatf("mul_busy_valid%0d", k), OUT_VALID, 0);
            check($sformatf("mul_busy_ready%0d", k), IN_READY, 0);
        end
        @(negedge CLK);
        check("mul_latency", OUT_VALID, 1);
        step();

        OUT_READY = 1'b0;
        send(4'h6, 8'hFF, 8'h04, 1, t0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check($sformatf("stall_valid%0d", k), OUT_VALID, 1);
            check($sformatf("stall_y%0d", k), Y, 8'hF0);
            check($sformatf("stall_c%0d", k), C, 1);
            check($sformatf("stall_ready%0d", k), IN_READY, 0);
        end
        step();
        OUT_READY = 1'b1;
        @(negedge CLK);
        step();

        send(4'hC, 8'h11, 8'h33, 0, t0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rst_mid_valid", OUT_VALID, 0);
        check("rst_mid_ready", IN_READY, 0);
        check("rst_mid_y", Y, 0);
        check("rst_mid_flags", {C, V, N, Z, ILLEGAL}, 0);
        @(negedge CLK);
        RST = 1'b0;
        model_cf = 1'b0;
        saw = 0;
        repeat (15) begin
            @(negedge CLK);
            if (OUT_VALID) saw++;
        end
        check("rst_discard", saw, 0);
        step();

        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1, t0);
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge CLK);
                    #1;
                    OUT_READY = ($urandom_range(0, 3) != 0);
                end
            end
        join
        OUT_READY = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge CLK);
        check("drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
